ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit with a DEPTH-entry prefetch queue between the PC/memory side and the decoder. It issues sequential fetch requests over a valid/ready memory port with variable response latency and buffers the returned instructions with their PCs and error flags. It supports redirect (branch/trap flush), including discarding a stale in-flight response. It sits between the instruction memory/bus and the IDU, and replaces the fixed two-state fetch sequencer.

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu_fifo.sv | 69 ++++++
 rtl/ifu_prefetch.sv | 139 +++++++++++++
 tb/tb_ifu_prefetch.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction prefetch unit.
// The entry layout is fixed at the default 32-bit PC; the top level re-declares it for other XLEN values.
package ifu_pkg;

  localparam int          IFU_XLEN_DEF     = 32;
  localparam logic [31:0] IFU_RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HALT
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN_DEF-1:0] pc;
    logic [31:0]             inst;
    logic                    err;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch queue: power-of-two ring buffer with synchronous flush.
// Storage is not reset; only the pointers and the occupancy count are.
module ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential fetch over a single-outstanding valid/ready port,
// buffering {pc, inst, err} in a prefetch queue, with redirect flush and stale-response drop.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + 33;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            err;
  } entry_t;

  ifu_state_e      r_state;
  ifu_state_e      w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] r_req_pc;
  logic            w_req_hs;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  entry_t          w_push_entry;
  entry_t          w_head;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  assign mem_req_valid = (r_state == REQ) && !w_full;
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_hs      = mem_req_valid && mem_req_ready;

  // Responses only land in WAIT; anything arriving in DROP or alongside a redirect is discarded.
  assign w_push       = (r_state == WAIT) && mem_rsp_valid && !redirect_valid;
  assign w_pop        = inst_valid && inst_ready && !redirect_valid;
  assign w_push_entry = '{pc: r_req_pc, inst: mem_rsp_data, err: mem_rsp_err};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (w_req_hs) begin
          w_state_nxt = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = (redirect_valid || !mem_rsp_err) ? REQ : HALT;
        end else if (redirect_valid) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (mem_rsp_valid) begin
          w_state_nxt = REQ;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect_valid) begin
      w_fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (w_req_hs) begin
      w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) begin
      r_req_pc <= r_fetch_pc;
    end
  end

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head fields read as zero when the queue is empty so unreset storage never leaks out.
  assign inst_valid = (w_count != '0);
  assign inst       = w_empty ? 32'h0 : w_head.inst;
  assign inst_pc    = w_empty ? '0 : w_head.pc;
  assign inst_err   = w_empty ? 1'b0 : w_head.err;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: a latency-programmable memory model feeds a
// scoreboard of expected queue entries that each scenario compares against what the decoder side pops.
module tb_ifu_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } ent_t;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        mem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  int          n_cmp = 0;
  int          n_fail = 0;

  bit          pend = 1'b0;
  logic [31:0] pend_pc = 32'h0;
  int          pend_wait = 0;
  int          lat = 1;
  int          drop_next = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_pc = 32'h0;

  ent_t        exp_q[$];
  ent_t        obs_q[$];
  logic [31:0] req_log[$];

  ifu_prefetch #(
    .XLEN     (32),
    .DEPTH    (2),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err)
  );

  always #5 clk = ~clk;

  // One clock: observe what the coming edge will do, then step to the next falling edge
  // and drive the memory response side for the following cycle.
  task automatic cycle();
    logic [31:0] d;
    logic        e;
    if (inst_valid && inst_ready && !redirect_valid) begin
      obs_q.push_back('{pc: inst_pc, data: inst, err: inst_err});
    end
    if (mem_req_valid && mem_req_ready && !rst) begin
      req_log.push_back(mem_req_addr);
      pend      = 1'b1;
      pend_pc   = mem_req_addr;
      pend_wait = lat;
    end
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_err   = 1'b0;
    if (pend) begin
      if (pend_wait <= 1) begin
        d = pend_pc ^ 32'h1357_9bdf;
        e = err_en && (pend_pc == err_pc);
        pend          = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        mem_rsp_err   = e;
        if (drop_next > 0) drop_next--;
        else exp_q.push_back('{pc: pend_pc, data: d, err: e});
      end else begin
        pend_wait--;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
    end
    n_cmp++;
    if (mem_req_addr !== RST_PC) begin
      n_fail++; $display("FAIL reset_req_addr: got %h want %h", mem_req_addr, RST_PC);
    end
    n_cmp++;
    if ({inst_valid, inst, inst_pc, inst_err} !== 66'h0) begin
      n_fail++; $display("FAIL reset_inst: got v=%b i=%h pc=%h e=%b want all 0", inst_valid, inst, inst_pc, inst_err);
    end
  endtask

  task automatic test_basic();
    int   first;
    ent_t o, x;
    lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1; req_log.delete();
    rst = 1'b0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k == 1) begin
        n_cmp++;
        if (mem_req_valid !== 1'b1) begin
          n_fail++; $display("FAIL basic_first_req: got %b want 1", mem_req_valid);
        end
      end
      if (first == 0 && inst_valid === 1'b1) first = k;
    end
    n_cmp++;
    if (first != 3) begin
      n_fail++; $display("FAIL basic_first_inst_valid: got cycle %0d want 3", first);
    end
    mem_req_ready = 1'b0;
    repeat (6) cycle();
    n_cmp++;
    if (req_log.size() < 3 || req_log[0] !== 32'h8000_0000 || req_log[1] !== 32'h8000_0004 || req_log[2] !== 32'h8000_0008) begin
      n_fail++; $display("FAIL basic_req_addrs: got %p want 80000000,80000004,80000008", req_log);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 4) begin
      n_fail++; $display("FAIL basic_count: got %0d want %0d (4 expected)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL basic_entry: got %h want %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    ent_t o, x;
    inst_ready = 1'b0; mem_req_ready = 1'b1; req_log.delete();
    repeat (10) cycle();
    n_cmp++;
    if (req_log.size() != 2) begin
      n_fail++; $display("FAIL bp_fill_reqs: got %0d want 2", req_log.size());
    end
    n_cmp++;
    if ({mem_req_valid, inst_valid} !== 2'b01) begin
      n_fail++; $display("FAIL bp_full: got req_valid=%b inst_valid=%b want 0 1", mem_req_valid, inst_valid);
    end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    repeat (8) cycle();
    n_cmp++;
    if (req_log.size() != 3 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_one_more: got %0d reqs valid=%b want 3 reqs valid=0", req_log.size(), mem_req_valid);
    end
    mem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (6) cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 3) begin
      n_fail++; $display("FAIL bp_count: got %0d want %0d (3 expected)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL bp_entry: got %h want %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_redirect_wait();
    bit   seen_v;
    ent_t o, x;
    lat = 3; inst_ready = 1'b1; mem_req_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1003; drop_next = 1;
    exp_q.delete();
    cycle();
    redirect_valid = 1'b0; req_log.delete();
    seen_v = 1'b0;
    for (int k = 0; k < 10 && req_log.size() == 0; k++) begin
      if (inst_valid !== 1'b0) seen_v = 1'b1;
      cycle();
    end
    mem_req_ready = 1'b0;
    if (inst_valid !== 1'b0) seen_v = 1'b1;
    n_cmp++;
    if (seen_v) begin
      n_fail++; $display("FAIL rw_inst_valid_low: got 1 want 0 before new data");
    end
    n_cmp++;
    if (req_log.size() != 1 || req_log[0] !== 32'h8000_1000) begin
      n_fail++; $display("FAIL rw_next_addr: got %p want 80001000", req_log);
    end
    repeat (8) cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++; $display("FAIL rw_count: got %0d want %0d (1 expected)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL rw_entry: got %h want %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_redirect_same();
    ent_t o, x;
    lat = 1; inst_ready = 1'b1; mem_req_ready = 1'b1; drop_next = 1;
    cycle();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000; req_log.delete();
    cycle();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({mem_req_valid, mem_req_addr, inst_valid} !== {1'b1, 32'h8000_2000, 1'b0}) begin
      n_fail++; $display("FAIL rs_next_req: got v=%b a=%h iv=%b want 1 80002000 0", mem_req_valid, mem_req_addr, inst_valid);
    end
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    repeat (6) cycle();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++; $display("FAIL rs_count: got %0d want %0d (1 expected)", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL rs_entry: got %h want %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_err_halt();
    ent_t o, x;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    cycle();
    redirect_valid = 1'b0;
    err_en = 1'b1; err_pc = 32'h8000_0008; lat = 1;
    mem_req_ready = 1'b1; inst_ready = 1'b1; req_log.delete();
    repeat (14) cycle();
    n_cmp++;
    if (req_log.size() != 3 || req_log[2] !== 32'h8000_0008 || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_halt_reqs: got %p valid=%b want 3 reqs ending 80000008, valid 0", req_log, mem_req_valid);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 3) begin
      n_fail++; $display("FAIL err_count: got %0d want %0d (3 expected)", obs_q.size(), exp_q.size());
    end
    n_cmp++;
    if (obs_q.size() != 3 || obs_q[2].err !== 1'b1 || obs_q[2].pc !== 32'h8000_0008) begin
      n_fail++; $display("FAIL err_flag: got %p want last entry pc 80000008 err 1", obs_q);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front(); n_cmp++;
      if (o !== x) begin n_fail++; $display("FAIL err_entry: got %h want %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
    err_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; req_log.delete();
    cycle();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h8000_0100}) begin
      n_fail++; $display("FAIL err_resume: got v=%b a=%h want 1 80000100", mem_req_valid, mem_req_addr);
    end
    cycle();
    mem_req_ready = 1'b0;
    repeat (6) cycle();
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL err_resume_entry: got %p want %p", obs_q, exp_q);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_async_reset();
    lat = 1; inst_ready = 1'b0; mem_req_ready = 1'b1;
    cycle();
    lat = 5;
    repeat (2) cycle();
    n_cmp++;
    if ({inst_valid, mem_req_valid} !== 2'b10) begin
      n_fail++; $display("FAIL ar_pre: got iv=%b rv=%b want 1 0", inst_valid, mem_req_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({inst_valid, mem_req_valid, mem_req_addr} !== {1'b0, 1'b0, RST_PC}) begin
      n_fail++; $display("FAIL ar_immediate: got iv=%b rv=%b a=%h want 0 0 %h", inst_valid, mem_req_valid, mem_req_addr, RST_PC);
    end
    pend = 1'b0; mem_rsp_valid = 1'b0; exp_q.delete(); obs_q.delete(); req_log.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; lat = 1; inst_ready = 1'b1;
    cycle();
    n_cmp++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, RST_PC}) begin
      n_fail++; $display("FAIL ar_restart: got v=%b a=%h want 1 %h", mem_req_valid, mem_req_addr, RST_PC);
    end
    cycle();
    mem_req_ready = 1'b0;
    repeat (6) cycle();
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].pc !== RST_PC) begin
      n_fail++; $display("FAIL ar_entry: got %p want %p at %h", obs_q, exp_q, RST_PC);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same();
    test_err_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
